// File: rtl/dds_timed_cmd_queue.sv
// dds_timed_cmd_queue
// Timestamped command FIFO feeding the GPO core. The head entry's timestamp
// is compared against the global timeline; a match is presented on gpo_data
// with a one-cycle counter_matched strobe, and stale entries are dropped and
// recorded as late.
module dds_timed_cmd_queue #(
    parameter  int unsigned FIFO_DEPTH = 16,
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      counter,
    input  logic             run,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [127:0]     wr_data,
    input  logic             error_clear,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             counter_matched,
    output logic [127:0]     gpo_data,
    output logic             overflow,
    output logic             late_error,
    output logic [127:0]     late_data
);

    localparam int unsigned AW = CNT_W - 1;

    logic [127:0]     mem [FIFO_DEPTH];
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] wr_ptr;

    logic [127:0] head;
    logic [63:0]  head_ts;
    logic         can_pop;
    logic         match;
    logic         late;
    logic         pop;
    logic         do_wr;
    logic         ovf_evt;

    // Occupancy status derived from the registered pointers
    always_comb begin
        count = wr_ptr - rd_ptr;
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    end

    // Show-ahead head compare and write/pop qualification
    always_comb begin
        head    = mem[rd_ptr[AW-1:0]];
        head_ts = head[127:64];
        can_pop = run && !empty && !flush;
        match   = can_pop && (head_ts == counter);
        late    = can_pop && (head_ts < counter);
        pop     = match || late;
        do_wr   = wr_en && !full && !flush;
        ovf_evt = wr_en && full && !flush;
    end

    // Entry storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointers, dispatch output and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            counter_matched <= 1'b0;
            gpo_data        <= '0;
            overflow        <= 1'b0;
            late_error      <= 1'b0;
            late_data       <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            counter_matched <= match;
            if (match) begin
                gpo_data <= head;
            end
            if (late && !late_error) begin
                late_data <= head;
            end
            overflow   <= ovf_evt || (overflow && !error_clear);
            late_error <= late || (late_error && !error_clear);
        end
    end

endmodule

// File: tb/tb_dds_timed_cmd_queue.sv
// Directed bench for dds_timed_cmd_queue with hand-computed expectations.
module tb_dds_timed_cmd_queue;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   counter;
    logic          run;
    logic          flush;
    logic          wr_en;
    logic [127:0]  wr_data;
    logic          error_clear;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          counter_matched;
    logic [127:0]  gpo_data;
    logic          overflow;
    logic          late_error;
    logic [127:0]  late_data;

    int vectors = 0;
    int errors  = 0;
    int strobes = 0;

    dds_timed_cmd_queue #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .counter         (counter),
        .run             (run),
        .flush           (flush),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .error_clear     (error_clear),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .counter_matched (counter_matched),
        .gpo_data        (gpo_data),
        .overflow        (overflow),
        .late_error      (late_error),
        .late_data       (late_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] ts, input logic [63:0] cmd);
        wr_en   = 1'b1;
        wr_data = {ts, cmd};
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_matched"}, counter_matched, 1'b0);
        chk({tag, "_gpo"}, gpo_data, '0);
        chk({tag, "_late_data"}, late_data, '0);
        chk({tag, "_overflow"}, overflow, 1'b0);
        chk({tag, "_late_error"}, late_error, 1'b0);
        chk({tag, "_count"}, count, '0);
        chk({tag, "_empty"}, empty, 1'b1);
        chk({tag, "_full"}, full, 1'b0);
    endtask

    initial begin
        reset = 1'b0; counter = '0; run = 1'b0; flush = 1'b0;
        wr_en = 1'b0; wr_data = '0; error_clear = 1'b0;
        #1;

        // Reset values
        do_reset();
        chk_reset_state("rst");

        // Basic dispatch: single strobe the cycle after counter == 100
        push(64'd100, 64'h1000_0000_0000_0ABC);
        chk("basic_count", count, 1);
        chk("basic_not_empty", empty, 1'b0);
        run = 1'b1;
        strobes = 0;
        for (int c = 90; c <= 110; c++) begin
            counter = 64'(c);
            step();
            chk($sformatf("basic_strobe_%0d", c), counter_matched, (c == 100));
            if (counter_matched) strobes++;
        end
        chk("basic_strobe_total", strobes, 1);
        chk("basic_gpo", gpo_data, {64'd100, 64'h1000_0000_0000_0ABC});
        chk("basic_empty_after", empty, 1'b1);

        // Consecutive dispatches 200,201,202
        run = 1'b0;
        push(64'd200, 64'hA0);
        push(64'd201, 64'hA1);
        push(64'd202, 64'hA2);
        chk("consec_count", count, 3);
        run = 1'b1;
        for (int c = 198; c <= 204; c++) begin
            counter = 64'(c);
            step();
            chk($sformatf("consec_strobe_%0d", c), counter_matched, (c >= 200 && c <= 202));
            if (c >= 200 && c <= 202)
                chk($sformatf("consec_gpo_%0d", c), gpo_data, {64'(c), 64'(160 + c - 200)});
        end
        chk("consec_gpo_hold", gpo_data, {64'd202, 64'hA2});

        // Late entry: ts=400 behind counter=500, ts=510 dispatches normally
        run = 1'b0;
        counter = 64'd500;
        push(64'd400, 64'h2000_0000_0000_0400);
        push(64'd510, 64'h2000_0000_0000_0510);
        run = 1'b1;
        step();
        chk("late_flag", late_error, 1'b1);
        chk("late_data", late_data, {64'd400, 64'h2000_0000_0000_0400});
        chk("late_no_strobe", counter_matched, 1'b0);
        chk("late_count", count, 1);
        for (int c = 501; c <= 512; c++) begin
            counter = 64'(c);
            step();
            chk($sformatf("late_strobe_%0d", c), counter_matched, (c == 510));
        end
        chk("late_gpo_510", gpo_data, {64'd510, 64'h2000_0000_0000_0510});
        error_clear = 1'b1;
        step();
        error_clear = 1'b0;
        chk("late_cleared", late_error, 1'b0);
        chk("late_data_kept", late_data, {64'd400, 64'h2000_0000_0000_0400});

        // Full and overflow
        do_reset();
        run = 1'b0;
        counter = 64'd0;
        for (int i = 0; i < 16; i++) push(64'(1000 + i), 64'(i));
        chk("full_flag", full, 1'b1);
        chk("full_count", count, 16);
        chk("full_no_ovf", overflow, 1'b0);
        push(64'd1100, 64'hDEAD);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_count", count, 16);
        // Write plus pop at full: write still dropped
        run = 1'b1;
        counter = 64'd1000;
        wr_en = 1'b1;
        wr_data = {64'd1200, 64'hBEEF};
        step();
        wr_en = 1'b0;
        run = 1'b0;
        chk("fullpop_count", count, 15);
        chk("fullpop_full", full, 1'b0);
        chk("fullpop_strobe", counter_matched, 1'b1);
        chk("fullpop_gpo", gpo_data, {64'd1000, 64'd0});
        chk("fullpop_ovf", overflow, 1'b1);

        // Flush with a concurrent write
        do_reset();
        for (int i = 0; i < 5; i++) push(64'(2000 + i), 64'(i));
        chk("flush_pre_count", count, 5);
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = {64'd2005, 64'h55};
        step();
        flush = 1'b0;
        wr_en = 1'b0;
        chk("flush_empty", empty, 1'b1);
        chk("flush_count", count, 0);
        chk("flush_ovf", overflow, 1'b0);
        run = 1'b1;
        strobes = 0;
        for (int c = 2000; c <= 2006; c++) begin
            counter = 64'(c);
            step();
            if (counter_matched) strobes++;
        end
        chk("flush_no_strobe", strobes, 0);
        chk("flush_no_late", late_error, 1'b0);

        // Duplicate timestamps: second one is late
        run = 1'b0;
        push(64'd300, 64'hAAAA);
        push(64'd300, 64'hBBBB);
        run = 1'b1;
        counter = 64'd300;
        step();
        chk("dup_strobe", counter_matched, 1'b1);
        chk("dup_gpo", gpo_data, {64'd300, 64'hAAAA});
        counter = 64'd301;
        step();
        chk("dup_no_strobe", counter_matched, 1'b0);
        chk("dup_late", late_error, 1'b1);
        chk("dup_late_data", late_data, {64'd300, 64'hBBBB});
        chk("dup_empty", empty, 1'b1);

        // Reset with a dispatch pending: everything back to reset values
        run = 1'b0;
        push(64'd900, 64'h9);
        push(64'd901, 64'h9);
        run = 1'b1;
        counter = 64'd900;
        reset = 1'b1;
        step();
        reset = 1'b0;
        run = 1'b0;
        chk_reset_state("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dds_timed_cmd_queue.md
# dds_timed_cmd_queue

Timestamped command queue that sits directly upstream of the DDS controller's GPO core. It buffers 128-bit commands of the form {64-bit timestamp, 64-bit DDS command word} and compares the head entry against the global 64-bit timeline counter. On a match it presents the entry on `gpo_data` with a one-cycle `counter_matched` strobe. Entries whose time has already passed are discarded and flagged as late.

## Interface
- `FIFO_DEPTH`, 16: number of entries; power of two, ≥ 2.
- `CNT_W`, $clog2(FIFO_DEPTH)+1: width of `count`; derived, not overridden.

Ports:
- `clk` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `counter` in 64: global timeline counter, increments by 1 per `clk` while running.
- `run` in 1: dispatch enable.
- `flush` in 1: discard all queued entries.
- `wr_en` in 1: write strobe.
- `wr_data` in 128: [127:64] timestamp, [63:0] command word (dest-sel in [63:60]).
- `error_clear` in 1: clears the sticky error flags.
- `full` out 1.
- `empty` out 1.
- `count` out CNT_W: occupancy.
- `counter_matched` out 1: one-cycle dispatch strobe to the GPO core.
- `gpo_data` out 128: dispatched entry; holds its value until the next dispatch.
- `overflow` out 1: sticky.
- `late_error` out 1: sticky.
- `late_data` out 128: first late entry since the last clear.

## Operation
- **Storage**
  - Circular buffer with rd/wr pointers of CNT_W bits; the MSB is the wrap bit.
  - `full` when the pointers differ only in the MSB; `empty` when they are equal.
  - Head = mem[rd_ptr], read combinationally (show-ahead), so consecutive dispatches are possible on consecutive cycles.
- **Write**
  - `wr_en` with `full`=0: store `wr_data`, wr_ptr+1.
  - `wr_en` with `full`=1: drop the write and set `overflow`. `full` is evaluated at the start of the cycle, so a pop in the same cycle does not free a slot.
- **Dispatch** (only when `run`=1 and `empty`=0; head timestamp = H):
  - H == `counter`: next cycle `counter_matched`=1 and `gpo_data`=head; rd_ptr+1.
  - H < `counter` (unsigned): pop without dispatch. Set `late_error`. If `late_error` was 0, capture head into `late_data`.
  - H > `counter`: wait.
- **`run`=0**: no pops, no late detection; writes still accepted.
- **`flush`**: rd_ptr ← wr_ptr at the next edge. In the same cycle, no dispatch and any write is dropped; `overflow` is not set. `gpo_data`, `late_data` and the flags are kept.
- **`error_clear`**: clears `overflow` and `late_error` (`late_data` is kept). A new error in the same cycle wins: the flag stays 1.
- **Equal timestamps back-to-back**: the second entry is late, because the counter has advanced.
- **Simultaneous write and pop**: both take effect; `count` is unchanged.
- **Priority**: `reset` > `flush` > pop/write.

## Timing
- **Reset values**: `counter_matched`=0, `gpo_data`=0, `late_data`=0, `overflow`=0, `late_error`=0, `count`=0, `empty`=1, `full`=0; pointers=0.
- **Write to head**: a write at edge t is visible as head in cycle t+1. It can dispatch in cycle t+1 if `counter`==H there, with the strobe in t+2.
- **Dispatch latency**: fixed at 1 cycle. The strobe is registered in the cycle after `counter`==H; software compensates.
- **Throughput**: one dispatch per cycle maximum.
- **Status and flags**: `count`/`full`/`empty` are registered and reflect all writes/pops at the same edge. `overflow` and `late_error` assert one cycle after the event.
- **Reset mid-operation**: all state returns to reset values at the next edge; a dispatch pending in that cycle is lost.

## Test plan
- **Basic dispatch**: reset; write {ts=100, cmd=0x1000_0000_0000_0ABC}; `run`=1, counter sweeps 90..110 → single `counter_matched` in the cycle after counter=100; `gpo_data`={100, 0x1000_0000_0000_0ABC}; `empty`=1 afterwards.
- **Consecutive**: write ts=200,201,202 → strobes on three consecutive cycles after counter=200,201,202, with data in order.
- **Late**: counter=500, write ts=400 then ts=510 → `late_error`=1, `late_data`.ts=400, no strobe for 400; ts=510 dispatches normally. `error_clear` → `late_error`=0, `late_data` retained.
- **Full/overflow**: write 16 entries with `run`=0 → `full`=1, `count`=16. 17th write → dropped, `overflow`=1. Same-cycle write+pop at full → write dropped, `count`=15.
- **Flush**: 5 entries queued; `flush` together with `wr_en` → `empty`=1, `count`=0, `overflow`=0, no strobe even when counter later hits those timestamps.
- **Duplicate timestamps and reset**: two entries with ts=300 → the first dispatches, the second is flagged late. Assert `reset` with entries pending → all outputs return to reset values next cycle.
